// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, format classes and the
// per-entry bundle held in the decode output buffer.
package decode_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_entry_t;

    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        fmt_e f;
        unique case (op)
            OP:                                    f = FMT_R;
            OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:  f = FMT_I;
            STORE:                                 f = FMT_S;
            BRANCH:                                f = FMT_B;
            LUI, AUIPC:                            f = FMT_U;
            JAL:                                   f = FMT_J;
            default:                               f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_imm.sv
// Immediate generator: reassembles the format-specific immediate bits
// and sign-extends from inst[31] to XLEN.
module decode_imm
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     inst,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            FMT_I: imm32 = 32'($signed(inst[31:20]));
            FMT_S: imm32 = 32'($signed({inst[31:25], inst[11:7]}));
            FMT_B: imm32 = 32'($signed({inst[31], inst[7], inst[30:25],
                                        inst[11:8], 1'b0}));
            FMT_U: imm32 = $signed({inst[31:12], 12'b0});
            FMT_J: imm32 = 32'($signed({inst[31], inst[19:12], inst[20],
                                        inst[30:21], 1'b0}));
            default: imm32 = '0;
        endcase
    end

    // Signed source makes the width cast sign-extend for XLEN=64.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational field split and legality check,
// results queued in a small FIFO toward execute.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    fmt_e            fmt_raw;
    fmt_e            fmt;
    logic            illegal;
    logic [6:0]      f7;
    logic [2:0]      f3;
    dec_entry_t      dec;
    logic [XLEN-1:0] imm;

    assign f7      = in_inst[31:25];
    assign f3      = in_inst[14:12];
    assign fmt_raw = opcode_fmt(in_inst[6:0]);

    always_comb begin
        illegal = 1'b0;
        if (in_inst[1:0] != 2'b11)
            illegal = 1'b1;
        if (fmt_raw == FMT_ILL)
            illegal = 1'b1;
        if (fmt_raw == FMT_R && f7 != 7'h00 && f7 != 7'h20)
            illegal = 1'b1;
        if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101)
            illegal = 1'b1;
    end

    assign fmt = illegal ? FMT_ILL : fmt_raw;

    always_comb begin
        dec         = '0;
        dec.opcode  = in_inst[6:0];
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.fmt     = fmt;
        dec.illegal = illegal;
    end

    decode_imm #(.XLEN(XLEN)) u_imm (
        .inst (in_inst[31:7]),
        .fmt  (fmt),
        .imm  (imm)
    );

    dec_entry_t      ent_q [BUF_DEPTH];
    logic [XLEN-1:0] pc_q  [BUF_DEPTH];
    logic [XLEN-1:0] imm_q [BUF_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    assign in_ready  = (count_q != CW'(BUF_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)
                tail_d = tail_q + PW'(1);
            if (pop)
                head_d = head_q + PW'(1);
            if (push && !pop)
                count_d = count_q + CW'(1);
            else if (pop && !push)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                ent_q[i] <= '0;
                pc_q[i]  <= '0;
                imm_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                ent_q[tail_q] <= dec;
                pc_q[tail_q]  <= in_pc;
                imm_q[tail_q] <= imm;
            end
        end
    end

    assign out_pc      = pc_q[head_q];
    assign out_imm     = imm_q[head_q];
    assign out_opcode  = ent_q[head_q].opcode;
    assign out_rd      = ent_q[head_q].rd;
    assign out_rs1     = ent_q[head_q].rs1;
    assign out_rs2     = ent_q[head_q].rs2;
    assign out_funct3  = ent_q[head_q].funct3;
    assign out_funct7  = ent_q[head_q].funct7;
    assign out_fmt     = ent_q[head_q].fmt;
    assign out_illegal = ent_q[head_q].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against a queue-based
// reference model derived from the RV32I field and immediate rules.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    decode_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_fmt     (out_fmt),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        int          fmt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t mq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i,
                                     input logic [31:0] pc);
        exp_t e;
        int   f7, f3, v;
        f7 = int'(i[31:25]);
        f3 = int'(i[14:12]);
        case (i[6:0])
            7'b0110011: e.fmt = 0;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111: e.fmt = 1;
            7'b0100011: e.fmt = 2;
            7'b1100011: e.fmt = 3;
            7'b0110111, 7'b0010111: e.fmt = 4;
            7'b1101111: e.fmt = 5;
            default: e.fmt = 7;
        endcase
        e.ill = (i[1:0] != 2'b11) || (e.fmt == 7)
             || (e.fmt == 0 && f7 != 0 && f7 != 32)
             || (f7 == 32 && f3 != 0 && f3 != 5);
        if (e.ill) e.fmt = 7;
        v = 0;
        case (e.fmt)
            1: begin
                v = int'(i[31:20]);
                if (v >= 2048) v -= 4096;
            end
            2: begin
                v = int'(i[31:25]) * 32 + int'(i[11:7]);
                if (v >= 2048) v -= 4096;
            end
            3: begin
                v = int'(i[31]) * 4096 + int'(i[7]) * 2048
                  + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                if (i[31]) v -= 8192;
            end
            4: v = int'(i & 32'hFFFF_F000);
            5: begin
                v = int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096
                  + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
                if (i[31]) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        e.imm  = 32'(v);
        e.inst = i;
        e.pc   = pc;
        return e;
    endfunction

    task automatic check_model();
        exp_t e;
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        if (mq.size() != 0) begin
            e = mq[0];
            chk("pc", 64'(out_pc), 64'(e.pc));
            chk("opcode", 64'(out_opcode), 64'(e.inst[6:0]));
            chk("rd", 64'(out_rd), 64'(e.inst[11:7]));
            chk("rs1", 64'(out_rs1), 64'(e.inst[19:15]));
            chk("rs2", 64'(out_rs2), 64'(e.inst[24:20]));
            chk("funct3", 64'(out_funct3), 64'(e.inst[14:12]));
            chk("funct7", 64'(out_funct7), 64'(e.inst[31:25]));
            chk("fmt", 64'(out_fmt), 64'(e.fmt));
            chk("imm", 64'(out_imm), 64'(e.imm));
            chk("illegal", 64'(out_illegal), 64'(e.ill));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic rdy,
                        input logic fl);
        bit push, pop;
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        push = v && (mq.size() < DEPTH) && !fl;
        pop  = (mq.size() != 0) && rdy && !fl;
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(ref_dec(inst, pc));
        end
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [11];
        logic [31:0] i;
        int          s, k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                7'b0010111, 7'b1110011, 7'b0001111};
        i = $urandom;
        s = $urandom_range(0, 15);
        if (s < 11) i[6:0] = ops[s];
        k = $urandom_range(0, 9);
        if (k < 3) i[31:25] = 7'h00;
        else if (k < 5) i[31:25] = 7'h20;
        else if (k == 5) i[31:25] = 7'h01;
        return i;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_opcode", 64'(out_opcode), 64'd0);
        chk("rst_fmt", 64'(out_fmt), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors with known decodes
        step(1, 32'h002081b3, 32'h100, 1, 0);
        chk("add_fmt", 64'(out_fmt), 64'd0);
        chk("add_rd", 64'(out_rd), 64'd3);
        chk("add_rs1", 64'(out_rs1), 64'd1);
        chk("add_rs2", 64'(out_rs2), 64'd2);
        chk("add_imm", 64'(out_imm), 64'd0);
        chk("add_ill", 64'(out_illegal), 64'd0);
        step(1, 32'h05408113, 32'h104, 1, 0);
        chk("addi_fmt", 64'(out_fmt), 64'd1);
        chk("addi_rd", 64'(out_rd), 64'd2);
        chk("addi_imm", 64'(out_imm), 64'h54);
        step(1, 32'hfff00093, 32'h108, 1, 0);
        chk("addi_neg", 64'(out_imm), 64'hFFFF_FFFF);
        step(1, 32'hFE208EE3, 32'h10c, 1, 0);
        chk("beq_fmt", 64'(out_fmt), 64'd3);
        chk("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        step(1, 32'h008000EF, 32'h110, 1, 0);
        chk("jal_fmt", 64'(out_fmt), 64'd5);
        chk("jal_imm", 64'(out_imm), 64'd8);
        step(1, 32'h123452B7, 32'h114, 1, 0);
        chk("lui_fmt", 64'(out_fmt), 64'd4);
        chk("lui_imm", 64'(out_imm), 64'h1234_5000);
        step(1, 32'h0020A423, 32'h118, 1, 0);
        chk("sw_fmt", 64'(out_fmt), 64'd2);
        chk("sw_imm", 64'(out_imm), 64'd8);
        step(1, 32'h00000000, 32'h11c, 1, 0);
        chk("zero_ill", 64'(out_illegal), 64'd1);
        chk("zero_fmt", 64'(out_fmt), 64'd7);
        chk("zero_imm", 64'(out_imm), 64'd0);
        step(1, 32'h022081b3, 32'h120, 1, 0);
        chk("mul_ill", 64'(out_illegal), 64'd1);
        chk("mul_fmt", 64'(out_fmt), 64'd7);
        chk("mul_rd", 64'(out_rd), 64'd3);
        step(0, 32'h0, 32'h0, 1, 0);

        // Backpressure: third push must be held off
        step(1, 32'h00100093, 32'h200, 0, 0);
        step(1, 32'h00200113, 32'h204, 0, 0);
        chk("bp_ready_full", 64'(in_ready), 64'd0);
        step(1, 32'h00300193, 32'h208, 0, 0);
        chk("bp_held_pc", 64'(out_pc), 64'h200);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("bp_second_pc", 64'(out_pc), 64'h204);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Flush with a same-cycle push
        step(1, 32'h00100093, 32'h300, 0, 0);
        step(1, 32'h00200113, 32'h304, 0, 0);
        step(1, 32'h00300193, 32'h308, 0, 1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-stream
        step(1, 32'h00100093, 32'h400, 0, 0);
        step(1, 32'h00200113, 32'h404, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_pc", 64'(out_pc), 64'd0);
        mq.delete();
        #1 rst = 1'b0;

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, rand_inst(),
                 $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I decode stage that sits between fetch and the register-file/execute stage of the core. It accepts one 32-bit instruction plus PC per cycle over a valid/ready handshake and splits it into fields, format class, sign-extended immediate and an illegal flag. Decoded results go into a small output FIFO so execute can stall without a combinational ready path back to fetch. A flush input discards all buffered work on a branch or trap.

## Interface
- XLEN, 32: datapath width for PC and immediate (32 or 64).
- BUF_DEPTH, 2: output FIFO entries (power of two, ≥2).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals (count != BUF_DEPTH).
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all entries; also drops the same-cycle input.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  execute consumes head.
- out_pc  out  XLEN  PC of head.
- out_opcode  out  7  inst[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / [19:15] / [24:20].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  instruction not decodable.

## Operation
- Decode is combinational on in_inst; the result is written to the FIFO tail on accept (in_valid && in_ready && !flush).
- Pop on out_valid && out_ready. Push and pop in the same cycle leave count unchanged. This is legal when full only if pop occurs; in_ready still reads 0 when full. No out_ready→in_ready path.
- Format map: 0110011→R; 0010011, 0000011, 1100111, 1110011, 0001111→I; 0100011→S; 1100011→B; 0110111, 0010111→U; 1101111→J; anything else→ILL.
- Immediates, all sign-extended from inst[31] to XLEN:
  - I = inst[31:20].
  - S = {inst[31:25], inst[11:7]}.
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U = {inst[31:12], 12'b0}.
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and ILL give imm = 0.
- Illegal when any of: inst[1:0] != 2'b11; fmt = ILL; R-type with funct7 ∉ {0x00, 0x20}; funct7 = 0x20 with funct3 ∉ {000, 101}. Illegal entries are still enqueued with out_fmt = ILL, out_illegal = 1, raw fields unchanged, and out_imm = 0.
- Flush: count, head and tail return to 0 on the next edge. Flush takes priority over a simultaneous push and pop.

## Timing
- Reset values: count, head and tail = 0; out_valid = 0; in_ready = 1. All out_* data fields read 0 (storage cleared).
- Latency: an instruction accepted at edge N is visible on out_* after edge N with out_valid = 1. Throughput is 1 per cycle while out_ready = 1.
- Outputs come straight from the FIFO head register; no combinational path from in_* to out_*.
- Pointers wrap modulo BUF_DEPTH; count is $clog2(BUF_DEPTH)+1 bits.
- Reset asserted mid-stream clears all entries immediately, without waiting for clk.
- Head data stays stable while out_valid && !out_ready.

## Structure
- Package decode_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM);
  - the fmt enum/localparams;
  - the packed decoded-entry struct.
- Sub-module decode_imm: combinational, (inst, fmt) → imm[XLEN-1:0].
- The FIFO is inline in decode_stage.

## Test plan
- ADD x3,x1,x2, 0x002081b3, out_ready=1 → one cycle later: fmt=0, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, imm=0, illegal=0.
- ADDI x2,x1,0x54, 0x05408113 → fmt=1, rd=2, rs1=1, imm=0x54. Then 0xfff00093 → imm=0xFFFFFFFF.
- BEQ x1,x2,-4, 0xFE208EE3 → fmt=3, imm=0xFFFFFFFC. Also JAL/LUI/SW vectors with known immediates.
- Backpressure, BUF_DEPTH=2, out_ready=0, three back-to-back pushes → in_ready drops after 2 accepts and the third is held. Raise out_ready → outputs emerge in order with no loss or duplication.
- 0x00000000 and an R-type with funct7=0x01 → out_illegal=1, fmt=7, imm=0.
- With 2 entries queued, assert flush together with in_valid → next cycle out_valid=0, count=0, and the flushed-cycle input is absent. Async rst pulse mid-stream gives the same result.
